uart_host_tx: RTL

- Synthesizable UART transmitter that drives the SoC harness `io_uart_rx` input. It replaces the constant-0 tie-off in the simulation top.
- It is the other direction of the harness `io_uart_tx`/tty path: a host-side byte stream is serialised into the SoC UART.
- It accepts bytes over a valid/ready interface, buffers them in a small FIFO and emits 8N1 or 8N2 frames at a programmable bit period.
- One instance per harness (DUT and variant), so both SoCs receive identical serial stimulus.

---
 rtl/uart_host_tx_pkg.sv | 18 +
 rtl/uart_host_tx_fifo.sv | 46 ++++
 rtl/uart_host_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_host_tx_pkg.sv
// Shared types and constants for the host-side UART transmitter (uart_host_tx).
// The PARITY state exists only when UART_HOST_TX_PARITY_EN is defined.
package uart_host_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_HOST_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/uart_host_tx_fifo.sv
// Byte FIFO for uart_host_tx: extra-MSB pointers, no read bypass, show-ahead head.
module uart_host_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full)
                wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
            if (pop && !empty)
                rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push && !full)
            mem[wr_q[AW-1:0]] <= din;
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count = wr_q - rd_q;
    assign dout  = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_host_tx.sv
// Host-to-SoC UART transmitter: valid/ready byte input, FIFO, 8N1/8N2 framing.
// Define UART_HOST_TX_PARITY_EN to add a parity bit (io_parity_odd selects odd).
module uart_host_tx
    import uart_host_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DIV_W-1:0]       io_div,
    input  logic                   io_nstop,
`ifdef UART_HOST_TX_PARITY_EN
    input  logic                   io_parity_odd,
`endif
    input  logic                   io_in_valid,
    output logic                   io_in_ready,
    input  logic [7:0]             io_in_bits,
    output logic                   io_txd,
    output logic                   io_busy,
    output logic [$clog2(DEPTH):0] io_count
);

    // Handshake: a byte transfers on any clock edge where io_in_valid && io_in_ready;
    // io_in_ready is !full from registered pointers, independent of io_in_valid.

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic                   nstop_q, nstop_d;
    logic                   parity_q, parity_d;
    logic                   pop, push, full, empty, tick;
    logic [7:0]             fifo_dout;

    assign push        = io_in_valid && io_in_ready;
    assign io_in_ready = !full;
    assign io_busy     = (state_q != IDLE) || !empty;
    assign tick        = (cnt_q == '0);

    uart_host_tx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (io_in_bits),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (io_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            nstop_q  <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            nstop_q  <= nstop_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        div_d    = div_q;
        nstop_d  = nstop_q;
        bit_d    = bit_q;
        parity_d = parity_q;
        pop      = 1'b0;
        io_txd   = IDLE_LEVEL;
        // Every bit boundary reloads the divisor latched at frame start.
        cnt_d    = tick ? div_q : cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                io_txd = 1'b0;
                if (tick)
                    state_d = DATA;
            end
            DATA: begin
                io_txd = shift_q[0];
                if (tick) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d   = '0;
`ifdef UART_HOST_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_HOST_TX_PARITY_EN
            PARITY: begin
                io_txd = parity_q;
                if (tick)
                    state_d = STOP;
            end
`endif
            STOP: begin
                io_txd = IDLE_LEVEL;
                if (tick) begin
                    if (bit_q[0] == nstop_q) begin
                        // Chain straight into the next frame when data is waiting.
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = fifo_dout;
            div_d   = io_div;
            cnt_d   = io_div;
            nstop_d = io_nstop;
            bit_d   = '0;
`ifdef UART_HOST_TX_PARITY_EN
            parity_d = (^fifo_dout) ^ io_parity_odd;
`else
            parity_d = 1'b0;
`endif
        end
    end

endmodule
